// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared register map and defaults for the gpio_irq peripheral
package gpio_pkg;

    localparam int ADDR_DEC_W = 4;
    localparam int GPIO_W_DEF = 16;

    localparam logic [ADDR_DEC_W-1:0] GPIO_DIR     = 4'h0;
    localparam logic [ADDR_DEC_W-1:0] GPIO_OUT     = 4'h1;
    localparam logic [ADDR_DEC_W-1:0] GPIO_IN      = 4'h2;
    localparam logic [ADDR_DEC_W-1:0] GPIO_OUT_SET = 4'h3;
    localparam logic [ADDR_DEC_W-1:0] GPIO_OUT_CLR = 4'h4;
    localparam logic [ADDR_DEC_W-1:0] GPIO_IEN     = 4'h5;
    localparam logic [ADDR_DEC_W-1:0] GPIO_RISE    = 4'h6;
    localparam logic [ADDR_DEC_W-1:0] GPIO_FALL    = 4'h7;
    localparam logic [ADDR_DEC_W-1:0] GPIO_PEND    = 4'h8;

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - pad input synchroniser with edge detection and post-reset edge mask
module gpio_sync_edge #(
    parameter int GPIO_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [GPIO_W-1:0] pin,
    output logic [GPIO_W-1:0] in_vec,
    output logic [GPIO_W-1:0] rise,
    output logic [GPIO_W-1:0] fall
);

    localparam int MASK_CYC = SYNC_STAGES + 1;
    localparam int CNT_W    = $clog2(MASK_CYC + 1);

    logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_W-1:0] prev_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              masking;

    // Pins already high through reset ripple through the zeroed chain; the
    // mask covers that window so they never look like edges.
    assign masking = (cnt_q != CNT_W'(MASK_CYC));
    assign in_vec  = sync_q[SYNC_STAGES-1];
    assign rise    = masking ? '0 : (in_vec & ~prev_q);
    assign fall    = masking ? '0 : (~in_vec & prev_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q[0] <= pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= in_vec;
            if (masking) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_irq.sv
// rtl/gpio_irq.sv - GPIO peripheral: register file, edge interrupts and valid/ready bus slave
module gpio_irq
    import gpio_pkg::*;
#(
    parameter int GPIO_W      = GPIO_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    input  logic              we_i,
    output logic [31:0]       data_o,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe_o,
    output logic              irq_o
);

    logic [GPIO_W-1:0]     dir_q, out_q, ien_q, rise_en_q, fall_en_q, pend_q;
    logic [GPIO_W-1:0]     in_vec, rise_vec, fall_vec;
    logic [GPIO_W-1:0]     wdata, pend_clr, pend_set;
    logic [ADDR_DEC_W-1:0] word;
    logic                  accept, wr;
    logic [31:0]           rdata;

    gpio_sync_edge #(
        .GPIO_W      (GPIO_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin    (gpio_i),
        .in_vec (in_vec),
        .rise   (rise_vec),
        .fall   (fall_vec)
    );

    assign word        = addr_i[5:2];
    assign wdata       = data_i[GPIO_W-1:0];
    assign req_ready_o = ~rsp_valid_o | rsp_ready_i;
    assign accept      = req_valid_i & req_ready_o;
    assign wr          = accept & we_i;
    assign pend_clr    = (wr && word == GPIO_PEND) ? wdata : '0;
    assign pend_set    = (rise_vec & rise_en_q) | (fall_vec & fall_en_q);

    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;
    assign irq_o     = |(pend_q & ien_q);

    always_comb begin
        rdata = '0;
        case (word)
            GPIO_DIR:  rdata[GPIO_W-1:0] = dir_q;
            GPIO_OUT:  rdata[GPIO_W-1:0] = out_q;
            GPIO_IN:   rdata[GPIO_W-1:0] = in_vec;
            GPIO_IEN:  rdata[GPIO_W-1:0] = ien_q;
            GPIO_RISE: rdata[GPIO_W-1:0] = rise_en_q;
            GPIO_FALL: rdata[GPIO_W-1:0] = fall_en_q;
            GPIO_PEND: rdata[GPIO_W-1:0] = pend_q;
            default:   rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_q       <= '0;
            out_q       <= '0;
            ien_q       <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            pend_q      <= '0;
            rsp_valid_o <= 1'b0;
            data_o      <= '0;
        end else begin
            if (wr) begin
                case (word)
                    GPIO_DIR:     dir_q     <= wdata;
                    GPIO_OUT:     out_q     <= wdata;
                    GPIO_OUT_SET: out_q     <= out_q | wdata;
                    GPIO_OUT_CLR: out_q     <= out_q & ~wdata;
                    GPIO_IEN:     ien_q     <= wdata;
                    GPIO_RISE:    rise_en_q <= wdata;
                    GPIO_FALL:    fall_en_q <= wdata;
                    default:      ;
                endcase
            end
            // A fresh edge outranks a software clear landing on the same cycle.
            pend_q <= (pend_q & ~pend_clr) | pend_set;

            if (accept) begin
                rsp_valid_o <= 1'b1;
                data_o      <= we_i ? '0 : rdata;
            end else if (rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
                data_o      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gpio_irq.sv
// tb/tb_gpio_irq.sv - directed self-checking bench for gpio_irq (16-pin and 8-pin builds in lockstep)
module tb_gpio_irq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic        we_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        rsp_ready_i = 1'b1;
    logic [15:0] gpio_i = 16'hFFFF;

    logic [31:0] data_o, data_o8;
    logic        req_ready_o, req_ready_o8;
    logic        rsp_valid_o, rsp_valid_o8;
    logic [15:0] gpio_o, gpio_oe_o;
    logic [7:0]  gpio_o8, gpio_oe_o8;
    logic        irq_o, irq_o8;

    int checks = 0;
    int failures = 0;
    logic [31:0] rd, rd8;

    always #5 clk = ~clk;

    gpio_irq #(.GPIO_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .data_i(data_i), .we_i(we_i),
        .data_o(data_o), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .gpio_i(gpio_i),
        .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o), .irq_o(irq_o)
    );

    gpio_irq #(.GPIO_W(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .data_i(data_i), .we_i(we_i),
        .data_o(data_o8), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o8),
        .rsp_valid_o(rsp_valid_o8), .rsp_ready_i(rsp_ready_i), .gpio_i(gpio_i[7:0]),
        .gpio_o(gpio_o8), .gpio_oe_o(gpio_oe_o8), .irq_o(irq_o8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] r16, output logic [31:0] r8);
        int n;
        @(negedge clk);
        we_i = we; addr_i = addr; data_i = wd; req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0; we_i = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_valid", {31'b0, rsp_valid_o}, 32'h1);
        r16 = data_o;
        r8  = data_o8;
    endtask

    initial begin
        // Reset with all pins held high
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        chk("rst_irq", {31'b0, irq_o}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
        chk("rst_req_ready", {31'b0, req_ready_o}, 32'h1);
        chk("rst_data", data_o, 32'h0);
        chk("rst_gpio_o", {16'b0, gpio_o}, 32'h0);
        chk("rst_gpio_oe", {16'b0, gpio_oe_o}, 32'h0);
        bus(1'b0, 32'h20, 32'h0, rd, rd8);
        chk("rst_pend", rd, 32'h0);
        chk("rst_pend8", rd8, 32'h0);
        bus(1'b0, 32'h08, 32'h0, rd, rd8);
        chk("rst_in", rd, 32'h0000FFFF);
        chk("rst_in8", rd8, 32'h000000FF);

        // Direction and atomic set/clear of outputs
        bus(1'b1, 32'h00, 32'h000000FF, rd, rd8);
        bus(1'b1, 32'h04, 32'h00001234, rd, rd8);
        bus(1'b1, 32'h0C, 32'h00000001, rd, rd8);
        bus(1'b1, 32'h10, 32'h00000030, rd, rd8);
        chk("gpio_oe", {16'b0, gpio_oe_o}, 32'h000000FF);
        chk("gpio_o", {16'b0, gpio_o}, 32'h00001205);
        chk("gpio_o8", {24'b0, gpio_o8}, 32'h00000005);
        bus(1'b0, 32'h04, 32'h0, rd, rd8);
        chk("out_rd", rd, 32'h00001205);

        // Edge interrupts: bit0 rising, bit1 falling
        @(negedge clk); gpio_i = 16'hFFFE;
        repeat (5) @(posedge clk);
        bus(1'b1, 32'h18, 32'h1, rd, rd8);
        bus(1'b1, 32'h1C, 32'h2, rd, rd8);
        bus(1'b1, 32'h14, 32'h3, rd, rd8);
        repeat (2) @(posedge clk);
        @(negedge clk); gpio_i = 16'hFFFD;
        repeat (2) @(posedge clk); #1;
        chk("irq_early", {31'b0, irq_o}, 32'h0);
        @(posedge clk); #1;
        chk("irq_set", {31'b0, irq_o}, 32'h1);
        bus(1'b0, 32'h20, 32'h0, rd, rd8);
        chk("pend_both", rd, 32'h00000003);
        bus(1'b1, 32'h20, 32'h1, rd, rd8);
        bus(1'b0, 32'h20, 32'h0, rd, rd8);
        chk("pend_w1c", rd, 32'h00000002);
        chk("irq_hold", {31'b0, irq_o}, 32'h1);
        bus(1'b1, 32'h20, 32'h2, rd, rd8);
        @(posedge clk); #1;
        chk("irq_clear", {31'b0, irq_o}, 32'h0);

        // Clear of bit0 lands on the same edge a new rising edge is detected
        @(negedge clk); gpio_i = 16'hFFFC;
        repeat (5) @(posedge clk);
        @(negedge clk); gpio_i = 16'hFFFD;
        repeat (2) @(posedge clk);
        bus(1'b1, 32'h20, 32'h1, rd, rd8);
        bus(1'b0, 32'h20, 32'h0, rd, rd8);
        chk("pend_set_wins", rd, 32'h00000001);

        // Back-pressure: response held while the next request waits
        repeat (2) @(posedge clk);
        @(negedge clk);
        rsp_ready_i = 1'b0; we_i = 1'b0; addr_i = 32'h08; req_valid_i = 1'b1;
        @(posedge clk); #1;
        chk("stall_rsp_valid", {31'b0, rsp_valid_o}, 32'h1);
        chk("stall_req_ready", {31'b0, req_ready_o}, 32'h0);
        chk("stall_in", data_o, 32'h0000FFFD);
        addr_i = 32'h00;
        gpio_i = 16'h00F0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stall_hold%0d", i), data_o, 32'h0000FFFD);
        end
        @(negedge clk); rsp_ready_i = 1'b1; #1;
        chk("release_req_ready", {31'b0, req_ready_o}, 32'h1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        chk("b2b_rsp_valid", {31'b0, rsp_valid_o}, 32'h1);
        chk("b2b_dir", data_o, 32'h000000FF);
        @(posedge clk); #1;
        chk("retire_valid", {31'b0, rsp_valid_o}, 32'h0);
        chk("retire_data", data_o, 32'h0);

        // Unmapped / write-only reads, and upper bits beyond GPIO_W
        bus(1'b0, 32'h24, 32'h0, rd, rd8);
        chk("rd_unmapped", rd, 32'h0);
        bus(1'b0, 32'h0C, 32'h0, rd, rd8);
        chk("rd_wo", rd, 32'h0);
        bus(1'b1, 32'h00, 32'hFFFFFFFF, rd, rd8);
        bus(1'b0, 32'h00, 32'h0, rd, rd8);
        chk("dir_w16", rd, 32'h0000FFFF);
        chk("dir_w8", rd8, 32'h000000FF);

        // Reset during a stalled transaction drops the response
        repeat (2) @(posedge clk);
        @(negedge clk);
        rsp_ready_i = 1'b0; we_i = 1'b0; addr_i = 32'h04; req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_valid", {31'b0, rsp_valid_o}, 32'h0);
        chk("rst_mid_oe", {16'b0, gpio_oe_o}, 32'h0);
        rst_n = 1'b1;
        rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_irq.md
Name: gpio_irq

Overview:
Parametrised general-purpose I/O peripheral with per-pin direction control, atomic set/clear of outputs, and edge-triggered interrupts. Inputs are synchronised before use. It sits on the core's valid/ready peripheral bus alongside the other memory-mapped slaves. It drives one level interrupt line to the interrupt controller.

Parameters:
GPIO_W, 16, number of pins; legal range 1..32; register bits [31:GPIO_W] read 0 and ignore writes
SYNC_STAGES, 2, input synchroniser depth; legal range 2..4

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
addr_i  input  32  byte address; decode uses addr_i[5:2] only
data_i  input  32  write data
we_i  input  1  1 = write, 0 = read
data_o  output  32  read data; valid while rsp_valid_o=1
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when req_valid_i & req_ready_o
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed
gpio_i  input  GPIO_W  asynchronous pad inputs
gpio_o  output  GPIO_W  pad output values (OUT register)
gpio_oe_o  output  GPIO_W  pad output enables (DIR register)
irq_o  output  1  level interrupt = |(PEND & IEN)

Behaviour:
- Clock is clk; reset is rst_n, synchronous, active-low. All state updates occur on the rising edge of clk only.
- Reset values: all registers 0; data_o=0; rsp_valid_o=0; irq_o=0; gpio_o=0; gpio_oe_o=0. After reset, req_ready_o=1.
- Register map (word offsets):
  - 0x00 DIR (RW)
  - 0x04 OUT (RW)
  - 0x08 IN (RO; synchronised pin value, read regardless of DIR)
  - 0x0C OUT_SET (WO; W1S into OUT)
  - 0x10 OUT_CLR (WO; W1C into OUT)
  - 0x14 IEN (RW)
  - 0x18 RISE (RW; rising-edge enable)
  - 0x1C FALL (RW; falling-edge enable)
  - 0x20 PEND (RW1C)
  - Reads of WO or unmapped offsets return 0. Writes to RO or unmapped offsets are ignored. The access still completes.
- Handshake:
  - Single outstanding transaction.
  - req_ready_o = ~rsp_valid_o | rsp_ready_i.
  - On an accepted request: the write takes effect at that edge, and read data is captured into data_o at that edge.
  - rsp_valid_o rises the next cycle and holds, with data_o stable, until rsp_valid_o & rsp_ready_i.
  - Back-to-back throughput is one transaction per cycle when rsp_ready_i is held at 1.
  - data_o returns to 0 when the response retires and no new read is accepted.
- Input path:
  - gpio_i passes through SYNC_STAGES flops into IN.
  - A prev register holds the last IN value.
  - rise = IN & ~prev; fall = ~IN & prev.
- Edge mask after reset:
  - A counter runs for SYNC_STAGES+1 cycles after reset deassertion; edges are ignored while it runs.
  - A pin held high through reset must not set PEND.
- PEND update per bit:
  - Set when (rise & RISE) | (fall & FALL).
  - Cleared by a write of 1.
  - If set and clear occur in the same cycle, set wins.
  - PEND latches regardless of IEN; IEN gates irq_o only.
- irq_o is the OR-reduction of registered state, with no combinational path from bus inputs.
- Read latency from a gpio_i change to an IN read reflecting it: SYNC_STAGES cycles, plus bus latency.
- Reset asserted mid-transaction: the response is dropped, rsp_valid_o=0 the next cycle, and no write is partially applied.

Decomposition:
- Shared package gpio_pkg: register offset localparams (GPIO_DIR..GPIO_PEND), address decode width (4), and a default GPIO_W.
- One sub-module, gpio_sync_edge (parameters GPIO_W, SYNC_STAGES). It contains the synchroniser, prev register, and post-reset mask counter, and outputs IN, rise, and fall vectors.
- The top level holds the register file, PEND logic, and handshake.

Test Plan:
- Reset with gpio_i=16'hFFFF held -> after 10 cycles PEND reads 0, IN reads 16'hFFFF, irq_o=0.
- Write DIR=16'h00FF, OUT=16'h1234, then OUT_SET=16'h0001, then OUT_CLR=16'h0030 -> gpio_oe_o=16'h00FF, final gpio_o=16'h1205, and an OUT read returns 32'h00001205.
- RISE=16'h0001, FALL=16'h0002, IEN=16'h0003; pulse gpio_i[0] 0->1 and gpio_i[1] 1->0 -> PEND=16'h0003 within SYNC_STAGES+1 cycles and irq_o=1. Writing PEND=16'h0001 leaves 16'h0002, and irq_o stays 1.
- Write PEND=16'h0001 on the same cycle a new bit-0 rising edge is detected -> PEND bit 0 remains 1.
- Hold rsp_ready_i=0 and issue a read of IN -> req_ready_o=0, and data_o stays stable across 5 cycles while gpio_i changes. rsp_ready_i=1 retires it, and the next request is accepted the same cycle.
- Read offset 0x24 and 0x0C -> data 0, response completes normally. Build with GPIO_W=8 and write DIR=32'hFFFFFFFF -> reads back 32'h000000FF.
